// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//
// Sequential instruction fetcher with a 2-entry {pc, instruction} buffer and at
// most one outstanding instruction-memory read. A redirect from the CPU flushes
// the buffer and restarts fetching at the (word-aligned) target. If a read is
// still in flight when the redirect arrives, its response is swallowed before
// the next fetch is issued.
//
// Optional build macro:
//   IFETCH_PERF_EN  adds the fetch_cnt output, which counts instructions
//                   handed to decode (wraps at 2^32, survives redirects).
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   redirect     branch/jump taken; flush and refetch
//   redirect_pc  branch/jump target (low two bits ignored)
//   imem_req     instruction memory read request
//   imem_addr    word-aligned fetch address, stable while imem_req is high
//   imem_ack     read data valid this cycle
//   imem_rdata   instruction word
//   inst_valid   buffer head holds an instruction for decode
//   inst_ready   decode accepts the head instruction
//   inst         instruction word at buffer head
//   inst_pc      address of inst
//   PC           next fetch address
//   fetch_cnt    (IFETCH_PERF_EN only) number of instructions popped
// -----------------------------------------------------------------------------
// state | meaning
// ------+----------------------------------------------------------------------
// IDLE  | no read in flight; waits for buffer space
// REQ   | read of PC in flight; response is pushed into the buffer
// DROP  | read in flight was made stale by a redirect; response is discarded
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] PC
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic [31:0] drop_addr_q, drop_addr_nxt;

  logic [31:0] fifo_pc   [0:1];
  logic [31:0] fifo_inst [0:1];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;

  logic        push, pop, flush;
  logic        space_after_push;
  logic [31:0] redirect_target;
  logic        unused_redirect_lsbs;

  assign redirect_target      = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign inst_valid = (count != 2'd0);
  assign inst       = fifo_inst[rd_ptr];
  assign inst_pc    = fifo_pc[rd_ptr];
  assign PC         = pc_q;
  assign imem_req   = (state != ST_IDLE);
  // In DROP the PC may already point at the redirect target, but the memory
  // must keep seeing the address of the read it is still serving.
  assign imem_addr  = (state == ST_DROP) ? drop_addr_q : pc_q;

  // A redirect cancels any pop presented in the same cycle.
  assign pop = inst_valid && inst_ready && !redirect;

  // Whether the buffer still has a free slot once this response is pushed.
  assign space_after_push = (count == 2'd0) || ((count == 2'd1) && pop);

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc_q;
    drop_addr_nxt = drop_addr_q;
    push          = 1'b0;
    flush         = 1'b0;

    if (redirect) begin
      flush  = 1'b1;
      pc_nxt = redirect_target;
    end

    case (state)
      ST_IDLE: begin
        // No read in flight, so buffer occupancy alone decides; acks here are
        // leftovers from a request abandoned by reset and are ignored.
        if (!redirect && (count < 2'd2)) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (redirect) begin
          if (imem_ack) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt     = ST_DROP;
            drop_addr_nxt = pc_q;
          end
        end else if (imem_ack) begin
          push      = 1'b1;
          pc_nxt    = pc_q + 32'd4;
          state_nxt = space_after_push ? ST_REQ : ST_IDLE;
        end
      end
      ST_DROP: begin
        if (imem_ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
    end else begin
      state       <= state_nxt;
      pc_q        <= pc_nxt;
      drop_addr_q <= drop_addr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= 2'd0;
      fifo_pc[0]   <= 32'd0;
      fifo_pc[1]   <= 32'd0;
      fifo_inst[0] <= 32'd0;
      fifo_inst[1] <= 32'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]   <= pc_q;
        fifo_inst[wr_ptr] <= imem_rdata;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= 32'd0;
    end else if (pop) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
//
// Self-checking bench for inst_fetch_unit. A transaction-level model (queue of
// {pc, inst} pairs plus "read in flight" / "read is stale" flags) is stepped on
// every rising edge and compared against the DUT on every falling edge.
// Directed sequences cover start-up latency, back-pressure, redirects while a
// read is in flight and address wrap; a random phase follows.
// Optional: define IFETCH_PERF_EN to also check fetch_cnt.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_ready;

  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, inst, inst_pc, pc_o;
  logic        w_imem_req, w_inst_valid;
  logic [31:0] w_imem_addr, w_inst, w_inst_pc, w_pc_o;
`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt, w_fetch_cnt;
`endif

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .PC(pc_o)
`ifdef IFETCH_PERF_EN
    , .fetch_cnt(fetch_cnt)
`endif
  );

  // Same stimulus, different reset address: exercises the 2^32 wrap.
  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_valid(w_inst_valid), .inst_ready(inst_ready),
    .inst(w_inst), .inst_pc(w_inst_pc), .PC(w_pc_o)
`ifdef IFETCH_PERF_EN
    , .fetch_cnt(w_fetch_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] q_pc[$];
  logic [31:0] q_inst[$];
  bit          m_busy;       // a read is in flight
  bit          m_stale;      // ...and its response must be thrown away
  logic [31:0] m_pc;
  logic [31:0] m_stale_addr;
  logic [31:0] m_cnt;

  task automatic model_reset();
    q_pc.delete();
    q_inst.delete();
    m_busy       = 1'b0;
    m_stale      = 1'b0;
    m_pc         = 32'h0000_0000;
    m_stale_addr = 32'h0000_0000;
    m_cnt        = 32'd0;
  endtask

  task automatic model_step();
    int n_before;
    bit do_pop;
    if (!rst) begin
      model_reset();
      return;
    end
    n_before = q_pc.size();
    do_pop   = (n_before != 0) && inst_ready && !redirect;
    if (redirect) begin
      q_pc.delete();
      q_inst.delete();
      if (m_busy && imem_ack) begin
        m_busy  = 1'b0;
        m_stale = 1'b0;
      end else if (m_busy && !m_stale) begin
        m_stale      = 1'b1;
        m_stale_addr = m_pc;
      end
      m_pc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (do_pop) begin
        void'(q_pc.pop_front());
        void'(q_inst.pop_front());
        m_cnt = m_cnt + 32'd1;
      end
      if (!m_busy) begin
        if (n_before < 2) m_busy = 1'b1;
      end else if (imem_ack) begin
        if (m_stale) begin
          m_busy  = 1'b0;
          m_stale = 1'b0;
        end else begin
          q_pc.push_back(m_pc);
          q_inst.push_back(mem_word(m_pc));
          m_pc   = m_pc + 32'd4;
          m_busy = (q_pc.size() < 2);
        end
      end
    end
  endtask

  task automatic compare_outputs();
    check_val("inst_valid", inst_valid, q_pc.size() != 0);
    check_val("imem_req", imem_req, m_busy);
    check_val("PC", pc_o, m_pc);
    if (m_busy || !rst) check_val("imem_addr", imem_addr, m_stale ? m_stale_addr : m_pc);
    if (q_pc.size() != 0) begin
      check_val("inst_pc", inst_pc, q_pc[0]);
      check_val("inst", inst, q_inst[0]);
    end else if (!rst) begin
      check_val("rst_inst_pc", inst_pc, 32'd0);
      check_val("rst_inst", inst, 32'd0);
    end
`ifdef IFETCH_PERF_EN
    check_val("fetch_cnt", fetch_cnt, m_cnt);
`endif
  endtask

  // ---------------- stimulus helpers ----------------
  bit mem_pend;

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  // Memory that answers each request one cycle after first seeing it.
  task automatic mem_wait1();
    imem_rdata = mem_word(imem_addr);
    if (imem_req) begin
      if (mem_pend) begin
        imem_ack = 1'b1;
        mem_pend = 1'b0;
      end else begin
        imem_ack = 1'b0;
        mem_pend = 1'b1;
      end
    end else begin
      imem_ack = 1'b0;
      mem_pend = 1'b0;
    end
  endtask

  // Reset asserted between edges to exercise the asynchronous path.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    check_val("async_rst_req", imem_req, 1'b0);
    check_val("async_rst_valid", inst_valid, 1'b0);
    model_reset();
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    inst_ready  = 1'b0;
    mem_pend    = 1'b0;
    imem_ack    = $urandom_range(0, 1);
    imem_rdata  = $urandom;
    repeat (2) tick();
    check_val("rst_pc_wrap", w_pc_o, 32'hFFFF_FFF8);
    check_val("rst_addr_wrap", w_imem_addr, 32'hFFFF_FFF8);
    imem_ack = 1'b0;
    rst      = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] seen[$];
  logic [31:0] w_seen[$];
  int          first_valid;
  int          pops;
  logic [31:0] exp_w;

  initial begin
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'd0;
    inst_ready  = 1'b0;
    mem_pend    = 1'b0;
    model_reset();
    @(negedge clk);

    // Start-up latency and sequential stream, both reset addresses.
    do_reset();
    inst_ready  = 1'b1;
    first_valid = -1;
    for (int c = 1; c <= 20; c++) begin
      mem_wait1();
      tick();
      if (inst_valid && first_valid < 0) first_valid = c;
      if (inst_valid) seen.push_back(inst_pc);
      if (w_inst_valid) w_seen.push_back(w_inst_pc);
    end
    check_val("first_valid_cycle", first_valid, 3);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("seq_pc%0d", i), (i < seen.size()) ? seen[i] : 32'hDEAD_BEEF, 32'(4 * i));
      exp_w = 32'hFFFF_FFF8 + 32'(4 * i);
      check_val($sformatf("wrap_pc%0d", i), (i < w_seen.size()) ? w_seen[i] : 32'hDEAD_BEEF, exp_w);
    end

    // Back-pressure: buffer fills to two entries and fetching stops.
    do_reset();
    inst_ready = 1'b0;
    imem_ack   = 1'b1;
    repeat (6) begin
      imem_rdata = mem_word(imem_addr);
      tick();
    end
    check_val("full_valid", inst_valid, 1'b1);
    check_val("full_head_pc", inst_pc, 32'h0);
    check_val("full_req", imem_req, 1'b0);
    check_val("full_PC", pc_o, 32'h8);
    inst_ready = 1'b1;
    tick();
    check_val("full_second_pc", inst_pc, 32'h4);
    inst_ready = 1'b0;
    imem_ack   = 1'b0;

    // Redirect while a read is in flight: stale response is dropped.
    do_reset();
    inst_ready = 1'b1;
    tick();
    check_val("drop_req_out", imem_req, 1'b1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    check_val("drop_req_held", imem_req, 1'b1);
    check_val("drop_addr_held", imem_addr, 32'h0);
    check_val("drop_PC", pc_o, 32'h0000_0100);
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    tick();
    imem_ack = 1'b0;
    check_val("drop_valid_low", inst_valid, 1'b0);
    tick();
    check_val("refetch_addr", imem_addr, 32'h0000_0100);
    mem_pend = 1'b0;
    for (int c = 0; c < 10 && !inst_valid; c++) begin
      mem_wait1();
      tick();
    end
    check_val("refetch_valid", inst_valid, 1'b1);
    check_val("refetch_pc", inst_pc, 32'h0000_0100);
    inst_ready = 1'b0;
    imem_ack   = 1'b0;

    // Redirect together with an ack and a pop.
    do_reset();
    tick();
    imem_ack   = 1'b1;
    imem_rdata = mem_word(imem_addr);
    tick();
    check_val("coinc_pre_valid", inst_valid, 1'b1);
    check_val("coinc_pre_addr", imem_addr, 32'h4);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    imem_rdata  = mem_word(imem_addr);
    inst_ready  = 1'b1;
    tick();
    redirect   = 1'b0;
    imem_ack   = 1'b0;
    inst_ready = 1'b0;
    check_val("coinc_valid", inst_valid, 1'b0);
    check_val("coinc_req", imem_req, 1'b0);
    tick();
    check_val("coinc_next_addr", imem_addr, 32'h0000_0200);

`ifdef IFETCH_PERF_EN
    // Counter survives a redirect.
    do_reset();
    inst_ready = 1'b1;
    pops       = 0;
    for (int c = 0; c < 60 && pops < 5; c++) begin
      mem_wait1();
      if (inst_valid) pops++;
      tick();
    end
    check_val("perf_pops", pops, 5);
    imem_ack    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = $urandom;
    tick();
    redirect   = 1'b0;
    inst_ready = 1'b0;
    check_val("perf_cnt_after_redirect", fetch_cnt, 32'd5);
`endif

    // Random phase, with a reset dropped in partway.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      inst_ready  = ($urandom_range(0, 9) < 7);
      imem_ack    = $urandom_range(0, 1);
      imem_rdata  = imem_req ? mem_word(imem_addr) : $urandom;
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, fetch address loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 redirect  input  1  branch/jump taken from CPU; flush and refetch.
REQ-005 redirect_pc  input  32  branch/jump target.
REQ-006 imem_req  output  1  instruction memory read request.
REQ-007 imem_addr  output  32  word-aligned fetch address.
REQ-008 imem_ack  input  1  read data valid this cycle.
REQ-009 imem_rdata  input  32  instruction word.
REQ-010 inst_valid  output  1  instruction available to CPU decode.
REQ-011 inst_ready  input  1  CPU decode accepts instruction.
REQ-012 inst  output  32  instruction word at FIFO head.
REQ-013 inst_pc  output  32  address of inst.
REQ-014 PC  output  32  next fetch address.

Function
REQ-015 The block SHALL hold a 2-entry FIFO of {pc, instruction} pairs and at most one outstanding memory request.
REQ-016 FSM states SHALL be IDLE, REQ (awaiting ack), DROP (awaiting ack of a discarded request).
REQ-017 IDLE->REQ SHALL occur when FIFO count + outstanding < 2 and redirect is low; imem_req rises the next cycle.
REQ-018 In REQ and DROP, imem_req SHALL be 1 and imem_addr SHALL stay stable until imem_ack.
REQ-019 On imem_ack in REQ without redirect: push {PC, imem_rdata}, PC <= PC + 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), state <= REQ if space remains, else IDLE.
REQ-020 inst_valid SHALL equal FIFO not-empty; inst/inst_pc SHALL show the head entry; pop on inst_valid && inst_ready.
REQ-021 Latency: imem_ack in cycle N SHALL give inst_valid in cycle N+1 when the FIFO was empty.
REQ-022 Push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-023 redirect SHALL take priority over all events: FIFO flushed, PC <= {redirect_pc[31:2], 2'b00}, same-cycle pop ignored.
REQ-024 Redirect in REQ without same-cycle ack SHALL go to DROP; ack in DROP SHALL be discarded, then go to IDLE.
REQ-025 Redirect coincident with imem_ack SHALL discard the data and go to IDLE.
REQ-026 Redirect while in DROP SHALL update PC and stay in DROP.
REQ-027 imem_addr SHALL equal PC in REQ; in DROP it SHALL hold the discarded address.

Reset
REQ-028 While rst is low: PC=RESET_PC, state=IDLE, FIFO empty, inst_valid=0, imem_req=0, inst=0, inst_pc=0, imem_addr=RESET_PC.
REQ-029 Reset asserted mid-request SHALL abandon the request; any later imem_ack arriving in IDLE SHALL be ignored.

Configuration
REQ-030 With IFETCH_PERF_EN defined: add output fetch_cnt (32 bits), reset 0, incremented by 1 per pop, wrapping at 2^32, not cleared by redirect.
REQ-031 Without IFETCH_PERF_EN: port fetch_cnt and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-032 Reset release, memory acks each request after 1 cycle, inst_ready=1 -> inst_pc sequence 0,4,8,12; first inst_valid 3 cycles after rst rises.
REQ-033 inst_ready=0 with continuous acks -> exactly 2 entries (pc 0, 4) buffered, imem_req low, PC=8.
REQ-034 redirect=1, redirect_pc=32'h0000_0103 while request outstanding -> state DROP; stale ack dropped; next fetch at 32'h0000_0100, inst_valid low until it returns.
REQ-035 redirect coincident with imem_ack and a pop -> FIFO empty, data discarded, next imem_addr = redirect target.
REQ-036 RESET_PC=32'hFFFF_FFF8, sequential fetch -> inst_pc 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000.
REQ-037 IFETCH_PERF_EN defined, 5 pops, then redirect -> fetch_cnt=5 after the redirect.
